cram_async_ctrl: RTL and testbench

CRAM_ASYNC_CTRL -- requirements
Module: cram_async_ctrl

---
 rtl/cram_async_ctrl_if.sv | 35 +++
 rtl/cram_async_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_cram_async_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cram_async_ctrl_if.sv
// cram_if: pin bundle between the controller and an asynchronous CellularRAM
// (muxed address/data bus).
//   data_out [15:0] : value the FPGA drives onto dq (address low word or write data)
//   data_in  [15:0] : value read back from dq
//   a        [5:0]  : upper address bits [21:16]
//   clk             : CellularRAM clock, held low in asynchronous mode
//   adv_n           : address valid, active low
//   cre             : configuration register enable, held low
//   ce0_n / ce1_n   : chip enables for the two devices, active low
//   oe_n / we_n     : output enable / write enable, active low
//   ub_n / lb_n     : upper / lower byte enables, active low
interface cram_if;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic [5:0]  a;
    logic        clk;
    logic        adv_n;
    logic        cre;
    logic        ce0_n;
    logic        ce1_n;
    logic        oe_n;
    logic        we_n;
    logic        ub_n;
    logic        lb_n;

    modport ctrl (
        output data_out, a, clk, adv_n, cre, ce0_n, ce1_n, oe_n, we_n, ub_n, lb_n,
        input  data_in
    );

    modport mem (
        input  data_out, a, clk, adv_n, cre, ce0_n, ce1_n, oe_n, we_n, ub_n, lb_n,
        output data_in
    );
endinterface

// File: rtl/cram_async_ctrl.sv
// cram_async_ctrl: single-access asynchronous CellularRAM controller.
// Each accepted request runs ADDR (adv_n low, address on dq), then READ or
// WRITE, then REC (chip deselected) before returning to IDLE.
//
// Ports:
//   clk, reset              : block clock, synchronous active-high reset
//   req_valid / req_ready   : request handshake
//   req_write               : 1 = write, 0 = read
//   req_addr [22:0]         : word address, bit 22 selects ce1_n over ce0_n
//   req_wdata [15:0]        : write data
//   req_be [1:0]            : byte enables (bit 1 upper, bit 0 lower)
//   rsp_valid               : one-cycle completion pulse (reads and writes)
//   rsp_rdata [15:0]        : last read data, held until the next read completes
//   fsm_state [2:0]         : debug view of the state register
//   cram                    : memory pin bundle (cram_if.ctrl)
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE; a requester seeing
// req_ready=0 keeps req_valid and its fields stable until the transfer edge.
// Every field is latched on the transfer edge, so the requester may change
// them freely afterwards.
module cram_async_ctrl #(
    parameter int ADV_CYCLES = 2,
    parameter int WR_CYCLES  = 4,
    parameter int RD_CYCLES  = 5,
    parameter int REC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [22:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_be,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [2:0]  fsm_state,
    cram_if.ctrl        cram
);

    generate
        if (ADV_CYCLES < 1 || WR_CYCLES < 1 || RD_CYCLES < 1 || REC_CYCLES < 1) begin : g_param_check
            $error("cram_async_ctrl: every phase length parameter must be at least 1");
        end
    endgenerate

    // The phase counter only ever holds (phase length - 1), so it needs
    // enough bits for the largest parameter minus one.
    localparam int MAX_AW = (ADV_CYCLES > WR_CYCLES) ? ADV_CYCLES : WR_CYCLES;
    localparam int MAX_RR = (RD_CYCLES > REC_CYCLES) ? RD_CYCLES : REC_CYCLES;
    localparam int MAX_P  = (MAX_AW > MAX_RR) ? MAX_AW : MAX_RR;
    localparam int CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] ADV_LOAD = CW'(ADV_CYCLES - 1);
    localparam logic [CW-1:0] WR_LOAD  = CW'(WR_CYCLES - 1);
    localparam logic [CW-1:0] RD_LOAD  = CW'(RD_CYCLES - 1);
    localparam logic [CW-1:0] REC_LOAD = CW'(REC_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_REC   = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // Latched request fields
    logic           write_q;
    logic [22:0]    addr_q;
    logic [15:0]    wdata_q;
    logic [1:0]     be_q;

    logic           accept;

    // Request fields as they will be after the coming edge; used so the
    // registered outputs of the first ADDR cycle already carry the new request.
    logic           sel_write;
    logic [22:0]    sel_addr;
    logic [15:0]    sel_wdata;
    logic [1:0]     sel_be;

    // Next values of the registered outputs
    logic           ce0_n_d, ce1_n_d, adv_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d;
    logic [5:0]     a_d;
    logic [15:0]    data_out_d;
    logic           rsp_valid_d;
    logic           capture;

    // req_ready is a register that is 1 exactly when state_q is IDLE
    assign accept    = req_valid && req_ready;
    assign sel_write = accept ? req_write : write_q;
    assign sel_addr  = accept ? req_addr  : addr_q;
    assign sel_wdata = accept ? req_wdata : wdata_q;
    assign sel_be    = accept ? req_be    : be_q;

    // Read data is taken on the edge that closes the final READ cycle
    assign capture   = (state_q == S_READ) && (cnt_q == '0);

    assign fsm_state = state_q;

    // ------------------------------------------------------------------
    // State register, latched request and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            write_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            cram.ce0_n    <= 1'b1;
            cram.ce1_n    <= 1'b1;
            cram.adv_n    <= 1'b1;
            cram.oe_n     <= 1'b1;
            cram.we_n     <= 1'b1;
            cram.ub_n     <= 1'b1;
            cram.lb_n     <= 1'b1;
            cram.a        <= '0;
            cram.data_out <= '0;
            cram.clk      <= 1'b0;
            cram.cre      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            if (accept) begin
                write_q   <= req_write;
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                be_q      <= req_be;
            end
            req_ready     <= (state_d == S_IDLE);
            rsp_valid     <= rsp_valid_d;
            if (capture) begin
                rsp_rdata <= cram.data_in;
            end
            cram.ce0_n    <= ce0_n_d;
            cram.ce1_n    <= ce1_n_d;
            cram.adv_n    <= adv_n_d;
            cram.oe_n     <= oe_n_d;
            cram.we_n     <= we_n_d;
            cram.ub_n     <= ub_n_d;
            cram.lb_n     <= lb_n_d;
            cram.a        <= a_d;
            cram.data_out <= data_out_d;
            cram.clk      <= 1'b0;
            cram.cre      <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; the counter is reloaded on every state entry and
    // only decremented while nonzero, so it cannot wrap.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ADDR;
                    cnt_d   = ADV_LOAD;
                end
            end
            S_ADDR: begin
                if (cnt_q == '0) begin
                    if (write_q) begin
                        state_d = S_WRITE;
                        cnt_d   = WR_LOAD;
                    end else begin
                        state_d = S_READ;
                        cnt_d   = RD_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_READ, S_WRITE: begin
                if (cnt_q == '0) begin
                    state_d = S_REC;
                    cnt_d   = REC_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_REC: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode of the next state; registered above so every pin
    // comes straight from a flop. IDLE and REC share the idle values,
    // which keep oe_n high so the FPGA owns dq and it never floats.
    // ------------------------------------------------------------------
    always_comb begin
        ce0_n_d     = 1'b1;
        ce1_n_d     = 1'b1;
        adv_n_d     = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        a_d         = '0;
        data_out_d  = '0;
        rsp_valid_d = 1'b0;
        case (state_d)
            S_ADDR: begin
                ce0_n_d    = sel_addr[22];
                ce1_n_d    = ~sel_addr[22];
                adv_n_d    = 1'b0;
                a_d        = sel_addr[21:16];
                data_out_d = sel_addr[15:0];
            end
            S_WRITE: begin
                ce0_n_d    = sel_addr[22];
                ce1_n_d    = ~sel_addr[22];
                we_n_d     = 1'b0;
                a_d        = sel_addr[21:16];
                data_out_d = sel_wdata;
                ub_n_d     = ~sel_be[1];
                lb_n_d     = ~sel_be[0];
            end
            S_READ: begin
                ce0_n_d    = sel_addr[22];
                ce1_n_d    = ~sel_addr[22];
                oe_n_d     = 1'b0;
                a_d        = sel_addr[21:16];
                ub_n_d     = 1'b0;
                lb_n_d     = 1'b0;
            end
            default: begin
            end
        endcase
        // Pulse only on the transition into REC, i.e. its first cycle
        if ((state_q == S_READ || state_q == S_WRITE) && state_d == S_REC) begin
            rsp_valid_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_cram_async_ctrl.sv
module tb_cram_async_ctrl;
    localparam int ADV = 2;
    localparam int WR  = 4;
    localparam int RD  = 5;
    localparam int REC = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [22:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [2:0]  fsm_state;
    logic [15:0] rd_word;

    logic        m_req_valid, m_req_ready, m_req_write;
    logic [22:0] m_req_addr;
    logic [15:0] m_req_wdata;
    logic [1:0]  m_req_be;
    logic        m_rsp_valid;
    logic [15:0] m_rsp_rdata;
    logic [2:0]  m_fsm_state;
    logic [15:0] m_rd_word;

    cram_if u_cram ();
    cram_if u_cram_m ();

    // Memory model: returns the staged word only while oe_n is low
    assign u_cram.data_in   = (!u_cram.oe_n)   ? rd_word   : 16'h0BAD;
    assign u_cram_m.data_in = (!u_cram_m.oe_n) ? m_rd_word : 16'h0BAD;

    cram_async_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .fsm_state (fsm_state),
        .cram      (u_cram)
    );

    cram_async_ctrl #(
        .ADV_CYCLES (1),
        .WR_CYCLES  (1),
        .RD_CYCLES  (1),
        .REC_CYCLES (1)
    ) dut_min (
        .clk       (clk),
        .reset     (reset),
        .req_valid (m_req_valid),
        .req_ready (m_req_ready),
        .req_write (m_req_write),
        .req_addr  (m_req_addr),
        .req_wdata (m_req_wdata),
        .req_be    (m_req_be),
        .rsp_valid (m_rsp_valid),
        .rsp_rdata (m_rsp_rdata),
        .fsm_state (m_fsm_state),
        .cram      (u_cram_m)
    );

    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_q[$];      // {is_read, expected rsp_rdata}
    logic [16:0] sb_entry;
    logic [15:0] last_rdata;

    // Scoreboard: every rsp_valid pops one expected completion
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_rsp: rsp_valid=1 rsp_rdata=%h, expected no response", rsp_rdata);
            end else begin
                sb_entry = exp_q.pop_front();
                if (rsp_rdata !== sb_entry[15:0]) begin
                    errors++;
                    $display("FAIL sb_rsp_rdata (read=%0b): got %h, expected %h", sb_entry[16], rsp_rdata, sb_entry[15:0]);
                end
            end
        end
    end

    // Bus-level rules checked every cycle on both instances
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ((!u_cram.oe_n && !u_cram.we_n) || (!u_cram.adv_n && !u_cram.oe_n) ||
                (!u_cram.ce0_n && !u_cram.ce1_n)) begin
                errors++;
                $display("FAIL bus_rules: oe_n=%b we_n=%b adv_n=%b ce0_n=%b ce1_n=%b, expected no conflict",
                         u_cram.oe_n, u_cram.we_n, u_cram.adv_n, u_cram.ce0_n, u_cram.ce1_n);
            end
            checks++;
            if ((!u_cram_m.oe_n && !u_cram_m.we_n) || (!u_cram_m.adv_n && !u_cram_m.oe_n) ||
                (!u_cram_m.ce0_n && !u_cram_m.ce1_n)) begin
                errors++;
                $display("FAIL bus_rules_min: oe_n=%b we_n=%b adv_n=%b ce0_n=%b ce1_n=%b, expected no conflict",
                         u_cram_m.oe_n, u_cram_m.we_n, u_cram_m.adv_n, u_cram_m.ce0_n, u_cram_m.ce1_n);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1, "watchdog expired");
    end

    // One complete access on the default-parameter instance, checked cycle by cycle
    task automatic do_access(input logic wr, input logic [22:0] addr, input logic [15:0] wd,
                             input logic [1:0] be, input logic [15:0] rw);
        int          p, last;
        logic        in_addr, in_data, sel;
        logic [8:0]  exp_v, got_v;
        logic [5:0]  exp_a;
        logic [15:0] exp_do;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL access_start_ready: req_ready=%b, expected 1", req_ready);
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        rd_word   = rw;
        if (wr) begin
            exp_q.push_back({1'b0, last_rdata});
        end else begin
            exp_q.push_back({1'b1, rw});
            last_rdata = rw;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = 23'($urandom);
        req_wdata = 16'($urandom);
        req_be    = ~be;
        p    = wr ? WR : RD;
        last = ADV + p + REC + 1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            in_addr = (c <= ADV);
            in_data = (c > ADV) && (c <= ADV + p);
            sel     = in_addr || in_data;
            exp_v = {!(sel && !addr[22]), !(sel && addr[22]), !in_addr,
                     !(in_data && !wr), !(in_data && wr),
                     in_data ? (wr ? ~be[1] : 1'b0) : 1'b1,
                     in_data ? (wr ? ~be[0] : 1'b0) : 1'b1,
                     (c == last), (c == ADV + p + 1)};
            got_v = {u_cram.ce0_n, u_cram.ce1_n, u_cram.adv_n, u_cram.oe_n, u_cram.we_n,
                     u_cram.ub_n, u_cram.lb_n, req_ready, rsp_valid};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL ctl_pins (wr=%0b cycle %0d) {ce0,ce1,adv,oe,we,ub,lb,rdy,rv}: got %b, expected %b",
                         wr, c, got_v, exp_v);
            end
            exp_a = sel ? addr[21:16] : 6'h00;
            checks++;
            if (u_cram.a !== exp_a) begin
                errors++;
                $display("FAIL addr_pins (wr=%0b cycle %0d): got %h, expected %h", wr, c, u_cram.a, exp_a);
            end
            if (!(in_data && !wr)) begin
                exp_do = in_addr ? addr[15:0] : (in_data ? wd : 16'h0000);
                checks++;
                if (u_cram.data_out !== exp_do) begin
                    errors++;
                    $display("FAIL data_out (wr=%0b cycle %0d): got %h, expected %h", wr, c, u_cram.data_out, exp_do);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [10:0] got_v;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got_v = {u_cram.ce0_n, u_cram.ce1_n, u_cram.adv_n, u_cram.oe_n, u_cram.we_n,
                 u_cram.ub_n, u_cram.lb_n, u_cram.cre, u_cram.clk, req_ready, rsp_valid};
        checks++;
        if (got_v !== 11'b1111111_00_10) begin
            errors++;
            $display("FAIL reset_ctl {ce0,ce1,adv,oe,we,ub,lb,cre,clk,rdy,rv}: got %b, expected 11111110010", got_v);
        end
        checks++;
        if ({u_cram.a, u_cram.data_out, rsp_rdata} !== 38'h0) begin
            errors++;
            $display("FAIL reset_data: a=%h data_out=%h rsp_rdata=%h, expected all zero",
                     u_cram.a, u_cram.data_out, rsp_rdata);
        end
        reset = 1'b0;
        last_rdata = 16'h0000;
    endtask

    task automatic test_reset_with_request();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 23'h012345;
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({u_cram.ce0_n, u_cram.ce1_n, u_cram.adv_n, req_ready} !== 4'b1111) begin
            errors++;
            $display("FAIL reset_req_ignored {ce0,ce1,adv,rdy}: got %b, expected 1111",
                     {u_cram.ce0_n, u_cram.ce1_n, u_cram.adv_n, req_ready});
        end
    endtask

    task automatic test_read();
        do_access(1'b0, 23'h012345, 16'h0000, 2'b00, 16'hBEEF);
    endtask

    task automatic test_write();
        do_access(1'b1, 23'h400010, 16'hA55A, 2'b10, 16'h1234);
        checks++;
        if (rsp_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL rdata_hold_after_write: got %h, expected BEEF", rsp_rdata);
        end
    endtask

    task automatic test_zero_be();
        do_access(1'b1, 23'h000777, 16'h0F0F, 2'b00, 16'h0000);
        do_access(1'b1, 23'h7FFFFF, 16'hFFFF, 2'b01, 16'h0000);
    endtask

    task automatic test_back_to_back();
        int acc1 = -1, acc2 = -1, gap = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 23'h0000AA;
        rd_word   = 16'h1357;
        exp_q.push_back({1'b1, 16'h1357});
        last_rdata = 16'h1357;
        for (int cyc = 0; cyc < 40 && acc2 < 0; cyc++) begin
            if (req_ready && req_valid) begin
                if (acc1 < 0) acc1 = cyc;
                else          acc2 = cyc;
            end
            if (acc1 >= 0 && cyc > acc1 && u_cram.ce0_n && u_cram.ce1_n) gap++;
            @(posedge clk);
            #1;
            if (acc1 == cyc) begin
                req_addr = 23'h4000BB;
            end
            if (acc2 == cyc) begin
                req_valid = 1'b0;
                rd_word   = 16'h2468;
                exp_q.push_back({1'b1, 16'h2468});
                last_rdata = 16'h2468;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        checks++;
        if (acc2 < 0 || (acc2 - acc1) != ADV + RD + REC + 1) begin
            errors++;
            $display("FAIL b2b_second_accept: distance %0d (acc2=%0d), expected %0d",
                     acc2 - acc1, acc2, ADV + RD + REC + 1);
        end
        checks++;
        if (gap < REC) begin
            errors++;
            $display("FAIL b2b_ce_gap: got %0d cycles, expected at least %0d", gap, REC);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_completion: req_ready=%b, expected 1", req_ready);
        end
    endtask

    task automatic test_reset_mid_read();
        do_access(1'b0, 23'h001111, 16'h0000, 2'b00, 16'hC0DE);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 23'h002222;
        rd_word   = 16'h7777;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) @(negedge clk);
        checks++;
        if (u_cram.oe_n !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_in_read: oe_n=%b in cycle 5, expected 0", u_cram.oe_n);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({u_cram.ce0_n, u_cram.ce1_n, u_cram.adv_n, u_cram.oe_n, u_cram.we_n, req_ready, rsp_valid} !== 7'b1111110) begin
            errors++;
            $display("FAIL rst_mid_idle {ce0,ce1,adv,oe,we,rdy,rv}: got %b, expected 1111110",
                     {u_cram.ce0_n, u_cram.ce1_n, u_cram.adv_n, u_cram.oe_n, u_cram.we_n, req_ready, rsp_valid});
        end
        checks++;
        if (rsp_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid_rdata: got %h, expected 0000", rsp_rdata);
        end
        reset = 1'b0;
        last_rdata = 16'h0000;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || u_cram.ce0_n !== 1'b1) begin
                errors++;
                $display("FAIL rst_mid_quiet (cycle %0d): rsp_valid=%b ce0_n=%b, expected 0 and 1",
                         c, rsp_valid, u_cram.ce0_n);
            end
        end
    endtask

    task automatic test_min_params();
        logic [4:0] exp_v, got_v;
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            checks++;
            if (m_req_ready !== 1'b1) begin
                errors++;
                $display("FAIL min_start_ready: got %b, expected 1", m_req_ready);
            end
            m_req_valid = 1'b1;
            m_req_write = (w == 1);
            m_req_addr  = 23'h4ABCDE;
            m_req_wdata = 16'h6699;
            m_req_be    = 2'b11;
            m_rd_word   = 16'h5A3C;
            @(posedge clk);
            #1;
            m_req_valid = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                // {ce1_n, adv_n, oe_n, we_n, ready, rsp_valid}: ADDR, data, REC, IDLE
                exp_v = {(c > 2), (c != 1), !(c == 2 && w == 0), !(c == 2 && w == 1), (c == 3)};
                got_v = {u_cram_m.ce1_n, u_cram_m.adv_n, u_cram_m.oe_n, u_cram_m.we_n, m_rsp_valid};
                checks++;
                if (got_v !== exp_v || m_req_ready !== (c == 4)) begin
                    errors++;
                    $display("FAIL min_timing (wr=%0d cycle %0d) {ce1,adv,oe,we,rv}: got %b rdy=%b, expected %b rdy=%b",
                             w, c, got_v, m_req_ready, exp_v, (c == 4));
                end
                if (c == 3) begin
                    checks++;
                    if (m_rsp_rdata !== 16'h5A3C) begin
                        errors++;
                        $display("FAIL min_rdata (wr=%0d): got %h, expected 5A3C", w, m_rsp_rdata);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            do_access(1'($urandom_range(0, 1)), 23'($urandom), 16'($urandom_range(0, 65535)),
                      2'($urandom_range(0, 3)), 16'($urandom_range(1, 65535)));
        end
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_be      = '0;
        rd_word     = '0;
        m_req_valid = 1'b0;
        m_req_write = 1'b0;
        m_req_addr  = '0;
        m_req_wdata = '0;
        m_req_be    = '0;
        m_rd_word   = '0;
        last_rdata  = '0;

        test_reset();
        test_reset_with_request();
        test_read();
        test_write();
        test_zero_be();
        test_back_to_back();
        test_reset_mid_read();
        test_min_params();
        test_random();

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
